lim_req_master: RTL and testbench

LIM_REQ_MASTER -- requirements
Module: lim_req_master

---
 rtl/lim_req_if.sv | 45 ++++
 rtl/lim_req_master.sv | 180 ++++++++++++++++++
 tb/tb_lim_req_master.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lim_req_if.sv
// Command, memory-bank and response signal bundle for the LiM request master.
interface lim_req_if #(
    parameter int ADDR_WIDTH = 20
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [7:0]            cmd_op;
    logic [23:0]           cmd_size;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_we;
    logic [3:0]            cmd_be;
    logic [31:0]           cmd_wdata;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_size, cmd_addr, cmd_we, cmd_be, cmd_wdata,
        output cmd_ready,
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_size, cmd_addr, cmd_we, cmd_be, cmd_wdata,
        input  cmd_ready,
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/lim_req_master.sv
// LiM request master: programs the function cell when the cached {size,op} differs,
// then issues the access and returns one response (with timeout).
//
// state     | meaning
// IDLE      | waiting for a command
// PROG      | writing {size,op} to the function cell, waiting for grant
// PROG_WAIT | function-cell write granted, waiting for completion
// ACC       | data access requested, waiting for grant
// ACC_WAIT  | data access granted, waiting for completion
// RSP       | response presented until accepted
module lim_req_master #(
    parameter int          ADDR_WIDTH  = 20,
    parameter logic [31:0] FUNCT_ADDR  = 32'h0001fffc,
    parameter int          TIMEOUT_CYC = 1024
) (
    input logic       clk_i,
    input logic       rst_ni,
    lim_req_if.master bus
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_WIDTH-1:0] FUNCT_MEM = FUNCT_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {IDLE, PROG, PROG_WAIT, ACC, ACC_WAIT, RSP} state_t;

    state_t                state;
    logic [7:0]            op_q;
    logic [23:0]           size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic                  funct_q;
    logic [31:0]           cache_q;
    logic                  cache_vld_q;
    logic [CNT_W-1:0]      wait_cnt;

    logic        cmd_hit;
    logic        cmd_funct;
    logic        wait_last;
    logic [31:0] done_cache;
    logic        done_vld;

    assign bus.cmd_ready = (state == IDLE);
    assign cmd_hit   = cache_vld_q && ({bus.cmd_size, bus.cmd_op} == cache_q);
    assign cmd_funct = ((bus.cmd_addr ^ FUNCT_MEM) & WORD_MASK) == '0;
    assign wait_last = (wait_cnt == CNT_LAST);

    // A direct access to the function cell keeps the cache coherent with the cell.
    always_comb begin
        done_cache = cache_q;
        done_vld   = cache_vld_q;
        if (funct_q) begin
            if (!we_q) begin
                done_cache = bus.mem_rdata;
                done_vld   = 1'b1;
            end else if (be_q == 4'hF) begin
                done_cache = wdata_q;
                done_vld   = 1'b1;
            end else begin
                done_vld   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            op_q          <= '0;
            size_q        <= '0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            be_q          <= '0;
            wdata_q       <= '0;
            funct_q       <= 1'b0;
            cache_q       <= '0;
            cache_vld_q   <= 1'b1;
            wait_cnt      <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q        <= bus.cmd_op;
                        size_q      <= bus.cmd_size;
                        addr_q      <= bus.cmd_addr;
                        we_q        <= bus.cmd_we;
                        be_q        <= bus.cmd_be;
                        wdata_q     <= bus.cmd_wdata;
                        funct_q     <= cmd_funct;
                        bus.mem_req <= 1'b1;
                        if (cmd_hit || cmd_funct) begin
                            state         <= ACC;
                            bus.mem_addr  <= bus.cmd_addr & WORD_MASK;
                            bus.mem_we    <= bus.cmd_we;
                            bus.mem_be    <= bus.cmd_be;
                            bus.mem_wdata <= bus.cmd_wdata;
                        end else begin
                            state         <= PROG;
                            bus.mem_addr  <= FUNCT_MEM;
                            bus.mem_we    <= 1'b1;
                            bus.mem_be    <= 4'hF;
                            bus.mem_wdata <= {bus.cmd_size, bus.cmd_op};
                        end
                    end
                end
                PROG, PROG_WAIT: begin
                    if ((state == PROG && bus.mem_gnt && bus.mem_rvalid) ||
                        (state == PROG_WAIT && bus.mem_rvalid)) begin
                        // Request stays high: the data access follows back-to-back.
                        cache_q       <= {size_q, op_q};
                        cache_vld_q   <= 1'b1;
                        state         <= ACC;
                        bus.mem_req   <= 1'b1;
                        bus.mem_addr  <= addr_q & WORD_MASK;
                        bus.mem_we    <= we_q;
                        bus.mem_be    <= be_q;
                        bus.mem_wdata <= wdata_q;
                    end else if (state == PROG) begin
                        if (bus.mem_gnt) begin
                            bus.mem_req <= 1'b0;
                            wait_cnt    <= '0;
                            state       <= PROG_WAIT;
                        end
                    end else if (wait_last) begin
                        cache_vld_q   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                        state         <= RSP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ACC, ACC_WAIT: begin
                    if (state == ACC && bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                    end
                    if ((state == ACC && bus.mem_gnt && bus.mem_rvalid) ||
                        (state == ACC_WAIT && bus.mem_rvalid)) begin
                        cache_q       <= done_cache;
                        cache_vld_q   <= done_vld;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= bus.mem_rdata;
                        state         <= RSP;
                    end else if (state == ACC) begin
                        if (bus.mem_gnt) begin
                            wait_cnt <= '0;
                            state    <= ACC_WAIT;
                        end
                    end else if (wait_last) begin
                        cache_vld_q   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                        state         <= RSP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lim_req_master.sv
// Directed bench for lim_req_master: inputs change and outputs are sampled at the falling edge.
module tb_lim_req_master;
    localparam int          AW    = 20;
    localparam logic [31:0] FADDR = 32'h0001fffc;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    lim_req_if #(.ADDR_WIDTH(AW)) bus ();

    lim_req_master #(
        .ADDR_WIDTH (AW),
        .FUNCT_ADDR (FADDR),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] op, input logic [23:0] size, input logic [AW-1:0] addr,
                        input logic we, input logic [3:0] be, input logic [31:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_size  = size;
        bus.cmd_addr  = addr;
        bus.cmd_we    = we;
        bus.cmd_be    = be;
        bus.cmd_wdata = wdata;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic complete(input logic [31:0] rdata);
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = '0;
        bus.cmd_size   = '0;
        bus.cmd_addr   = '0;
        bus.cmd_we     = 1'b0;
        bus.cmd_be     = '0;
        bus.cmd_wdata  = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.rsp_ready  = 1'b0;
        tick();
        tick();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_mem_req",   32'(bus.mem_req),   32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
        rst_n = 1'b1;
        tick();

        // plain load, cache matches reset value of the funct cell
        send(8'h00, 24'd0, 20'h00040, 1'b0, 4'hF, 32'h0);
        check("t1_req",   32'(bus.mem_req),   32'd1);
        check("t1_addr",  32'(bus.mem_addr),  32'h40);
        check("t1_we",    32'(bus.mem_we),    32'd0);
        check("t1_ready", 32'(bus.cmd_ready), 32'd0);
        complete(32'hCAFE0001);
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_rsp_rdata", bus.rsp_rdata,      32'hCAFE0001);
        check("t1_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("t1_req_fall",  32'(bus.mem_req),   32'd0);
        release_rsp();
        check("t1_idle_ready", 32'(bus.cmd_ready), 32'd1);
        check("t1_idle_valid", 32'(bus.rsp_valid), 32'd0);

        // range op: program funct cell, then access with delayed completion
        send(8'h03, 24'd8, 20'h00100, 1'b1, 4'h3, 32'h12345678);
        check("t2_prog_req",   32'(bus.mem_req),   32'd1);
        check("t2_prog_addr",  32'(bus.mem_addr),  32'h1fffc);
        check("t2_prog_we",    32'(bus.mem_we),    32'd1);
        check("t2_prog_be",    32'(bus.mem_be),    32'hF);
        check("t2_prog_wdata", bus.mem_wdata,      32'h00000803);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        check("t2_prog_wait_req", 32'(bus.mem_req), 32'd0);
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        check("t2_acc_req",   32'(bus.mem_req),  32'd1);
        check("t2_acc_addr",  32'(bus.mem_addr), 32'h100);
        check("t2_acc_we",    32'(bus.mem_we),   32'd1);
        check("t2_acc_be",    32'(bus.mem_be),   32'h3);
        check("t2_acc_wdata", bus.mem_wdata,     32'h12345678);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        repeat (11) tick();
        check("t2_wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA5A50000;
        tick();
        bus.mem_rvalid = 1'b0;
        check("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t2_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("t2_rsp_rdata", bus.rsp_rdata,      32'hA5A50000);
        release_rsp();
        send(8'h03, 24'd8, 20'h00100, 1'b1, 4'h3, 32'h12345678);
        check("t2_skip_prog_addr",  32'(bus.mem_addr), 32'h100);
        check("t2_skip_prog_wdata", bus.mem_wdata,     32'h12345678);
        complete(32'h00000011);
        check("t2_second_rdata", bus.rsp_rdata, 32'h11);
        release_rsp();

        // grant withheld for 5 cycles; request must hold still
        send(8'h03, 24'd8, 20'h002A7, 1'b1, 4'h5, 32'hDEADBEEF);
        repeat (5) begin
            check("t3_hold_req",   32'(bus.mem_req),  32'd1);
            check("t3_hold_addr",  32'(bus.mem_addr), 32'h2A4);
            check("t3_hold_we",    32'(bus.mem_we),   32'd1);
            check("t3_hold_be",    32'(bus.mem_be),   32'h5);
            check("t3_hold_wdata", bus.mem_wdata,     32'hDEADBEEF);
            tick();
        end
        check("t3_req_before_gnt", 32'(bus.mem_req), 32'd1);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        check("t3_req_fall", 32'(bus.mem_req), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BAD0001;
        tick();
        bus.mem_rvalid = 1'b0;
        check("t3_store_rdata", bus.rsp_rdata, 32'h0BAD0001);
        release_rsp();

        // timeout after 16 cycles in ACC_WAIT, then reprogramming
        send(8'h03, 24'd8, 20'h00080, 1'b0, 4'hF, 32'h0);
        check("t4_acc_addr", 32'(bus.mem_addr), 32'h80);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt   = 1'b0;
        bus.mem_rdata = 32'h55555555;
        repeat (15) tick();
        check("t4_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("t4_to_valid", 32'(bus.rsp_valid), 32'd1);
        check("t4_to_err",   32'(bus.rsp_err),   32'd1);
        check("t4_to_rdata", bus.rsp_rdata,      32'd0);
        release_rsp();
        send(8'h03, 24'd8, 20'h00084, 1'b0, 4'hF, 32'h0);
        check("t4_reprog_addr",  32'(bus.mem_addr), 32'h1fffc);
        check("t4_reprog_wdata", bus.mem_wdata,     32'h00000803);
        complete(32'h0);
        check("t4_direct_acc_req",  32'(bus.mem_req),  32'd1);
        check("t4_direct_acc_addr", 32'(bus.mem_addr), 32'h84);
        complete(32'h600D0004);
        check("t4_ok_valid", 32'(bus.rsp_valid), 32'd1);
        check("t4_ok_err",   32'(bus.rsp_err),   32'd0);
        check("t4_ok_rdata", bus.rsp_rdata,      32'h600D0004);

        // response back-pressure; stray gnt/rvalid/cmd ignored in RSP
        bus.cmd_valid  = 1'b1;
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFFFFFF;
        repeat (3) begin
            tick();
            check("t5_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("t5_hold_rdata", bus.rsp_rdata,      32'h600D0004);
            check("t5_hold_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.cmd_valid  = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        release_rsp();
        check("t5_rel_valid", 32'(bus.rsp_valid), 32'd0);
        check("t5_rel_ready", 32'(bus.cmd_ready), 32'd1);
        check("t5_rel_req",   32'(bus.mem_req),   32'd0);

        // direct write to the funct cell bypasses PROG and updates the cache
        send(8'h77, 24'd5, 20'h1fffc, 1'b1, 4'hF, 32'h0);
        check("t6_bypass_req",   32'(bus.mem_req),  32'd1);
        check("t6_bypass_addr",  32'(bus.mem_addr), 32'h1fffc);
        check("t6_bypass_wdata", bus.mem_wdata,     32'h0);
        complete(32'h0);
        release_rsp();
        send(8'h00, 24'd0, 20'h00010, 1'b0, 4'hF, 32'h0);
        check("t6_cache_hit_addr", 32'(bus.mem_addr), 32'h10);
        complete(32'h00000010);
        release_rsp();

        // reset in ACC_WAIT abandons the transaction
        send(8'h00, 24'd0, 20'h00020, 1'b0, 4'hF, 32'h0);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("t7_rst_req",   32'(bus.mem_req),   32'd0);
        check("t7_rst_addr",  32'(bus.mem_addr),  32'd0);
        check("t7_rst_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        rst_n          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12121212;
        tick();
        tick();
        bus.mem_rvalid = 1'b0;
        check("t7_no_rsp",      32'(bus.rsp_valid), 32'd0);
        tick();
        check("t7_no_rsp_late", 32'(bus.rsp_valid), 32'd0);
        check("t7_idle_ready",  32'(bus.cmd_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
